// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and common line constants.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              tx_next;
    logic              pop;
    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic              bit_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign in_ready = !full;
    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign busy     = (state != TX_IDLE);
    assign tx_done  = (state == TX_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    bit_next   = '0;
                    tx_next    = 1'b0;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    tx_next    = shift[0];
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_next    = 1'b1;
                        state_next = TX_STOP;
                    end else begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued frames leave no gap.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        bit_next   = '0;
                        tx_next    = 1'b0;
                        state_next = TX_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = TX_IDLE;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: queue/timeline model checked every cycle, an independent line decoder, and directed scenarios.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of accepted bytes plus the position inside the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] started_q[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_act = 1'b0;
    int         m_t   = 0;
    bit         m_on  = 1'b0;
    bit         m_acc;
    bit         m_fend;
    bit         m_start;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            started_q.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_on  = 1'b1;
        end else begin
            m_acc   = in_valid && (mq.size() < DEPTH);
            m_fend  = m_act && (m_t == FRAME - 1);
            m_start = (!m_act || m_fend) && (mq.size() > 0);
            if (m_start) begin
                m_cur = mq.pop_front();
                started_q.push_back(m_cur);
                m_act = 1'b1;
                m_t   = 0;
            end else if (m_fend) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_t++;
            end
            if (m_acc) mq.push_back(in_data);
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    always @(negedge clk) begin
        if (m_on) begin
            chk("tx", tx, exp_tx());
            chk("busy", busy, m_act);
            chk("tx_done", tx_done, m_act && (m_t == FRAME - 1));
            chk("fifo_count", fifo_count, mq.size());
            chk("in_ready", in_ready, mq.size() < DEPTH);
        end
    end

    // Independent mid-bit sampling receiver on the serial line.
    logic [7:0] rx_log[$];
    bit         d_act  = 1'b0;
    int         d_cnt  = 0;
    int         d_b    = 0;
    logic [7:0] d_sh   = 8'h00;
    logic       d_prev = 1'b1;
    int         done_cnt = 0;
    logic [7:0] d_exp;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (rst) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (d_prev === 1'b1 && tx === 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt % CPB == CPB / 2) begin
                d_b = d_cnt / CPB;
                if (d_b == 0) begin
                    chk("rx_start_bit", tx, 1'b0);
                end else if (d_b <= 8) begin
                    d_sh[d_b-1] = tx;
                end else begin
                    chk("rx_stop_bit", tx, 1'b1);
                    rx_log.push_back(d_sh);
                    chk("rx_frame_started", started_q.size() > 0, 1'b1);
                    if (started_q.size() > 0) begin
                        d_exp = started_q.pop_front();
                        chk("rx_byte", d_sh, d_exp);
                    end
                    d_act = 1'b0;
                end
            end
        end
        d_prev = tx;
    end

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_log.size()) return 32'(rx_log[i]);
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    logic [9:0] got_bits;
    int         done_at;
    int         gaps;
    int         cnt;
    logic [7:0] sent[$];
    logic [7:0] exp3 [3];

    initial begin
        exp3[0] = 8'h55; exp3[1] = 8'hAA; exp3[2] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", fifo_count, 4'd0);
        rst = 1'b0;

        // Single byte 0x41 into an idle block.
        @(negedge clk); in_data = 8'h41; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("lat_tx_still_idle", tx, 1'b1);
        chk("lat_count_one", fifo_count, 4'd1);
        done_cnt = 0; done_at = 0; got_bits = '0; rx_log.delete();
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (c == 1) chk("lat_tx_low", tx, 1'b0);
            if (c % CPB == CPB / 2 && c < FRAME) got_bits[c/CPB] = tx;
            if (tx_done) done_at = c;
        end
        chk("b41_bits", got_bits, 10'b10_1000_0010);
        chk("b41_done_cnt", done_cnt, 1);
        chk("b41_done_at", done_at, 160);
        chk("b41_busy_after", busy, 1'b0);
        chk("b41_rx", rx_at(0), 8'h41);

        // Burst 0x55, 0xAA, 0x00 on consecutive cycles.
        rx_log.delete(); done_cnt = 0; done_at = 0; gaps = 0;
        @(negedge clk); in_data = 8'h55; in_valid = 1'b1;
        @(negedge clk); in_data = 8'hAA;
        @(negedge clk); in_data = 8'h00;
        @(negedge clk); in_valid = 1'b0;
        for (int c = 3; c <= 500; c++) begin
            @(negedge clk);
            if (tx_done) done_at = c;
            if (c <= 480 && !busy) gaps++;
        end
        chk("burst_done_cnt", done_cnt, 3);
        chk("burst_last_done", done_at, 480);
        chk("burst_gaps", gaps, 0);
        chk("burst_rx_n", rx_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("burst_rx", rx_at(i), exp3[i]);

        // Nine writes fill shifter plus FIFO; the tenth is dropped.
        rx_log.delete();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); in_data = 8'(i); in_valid = 1'b1;
        end
        @(negedge clk); in_data = 8'hEE;
        chk("full_count", fifo_count, 4'd8);
        chk("full_in_ready", in_ready, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        chk("full_drop_count", fifo_count, 4'd8);
        cnt = 0;
        while ((rx_log.size() < 9 || busy) && cnt < 1700) begin
            @(negedge clk); cnt++;
        end
        chk("fill_rx_n", rx_log.size(), 9);
        for (int i = 0; i < 9; i++) chk("fill_rx", rx_at(i), 32'(i + 1));

        // Reset in the middle of a 0xF0 frame with a write in the reset cycle.
        rx_log.delete();
        @(negedge clk); in_data = 8'hF0; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h33;
        @(negedge clk); in_valid = 1'b0;
        for (int c = 2; c <= 68; c++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", fifo_count, 4'd1);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_tx", tx, 1'b1);
        chk("abort_count", fifo_count, 4'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        done_cnt = 0; gaps = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) gaps++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_line_idle", gaps, 0);
        chk("abort_rx_n", rx_log.size(), 0);

        // Loopback of 256 random bytes, writing whenever the FIFO has room.
        rx_log.delete(); sent.delete(); done_cnt = 0; cnt = 0;
        while (sent.size() < 256 && cnt < 256 * FRAME + 2000) begin
            @(negedge clk); cnt++;
            if (in_ready) begin
                in_data  = 8'($urandom_range(0, 255));
                in_valid = 1'b1;
                sent.push_back(in_data);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk); in_valid = 1'b0;
        cnt = 0;
        while ((rx_log.size() < 256 || busy) && cnt < 3000) begin
            @(negedge clk); cnt++;
        end
        chk("loop_sent_n", sent.size(), 256);
        chk("loop_rx_n", rx_log.size(), 256);
        chk("loop_done_n", done_cnt, 256);
        for (int i = 0; i < 256; i++) begin
            if (i < sent.size()) chk("loop_rx", rx_at(i), sent[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clk cycles per UART bit (9600 Bd at 100 MHz); legal range 4..16383.
REQ-002 Parameter FIFO_DEPTH, default 8, byte entries in the transmit FIFO; power of two, 2..64.
REQ-003 Port clk, input, 1, rising-edge system clock.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port in_data, input, 8, byte to transmit.
REQ-006 Port in_valid, input, 1, in_data is valid this cycle.
REQ-007 Port in_ready, output, 1, FIFO can accept a byte this cycle.
REQ-008 Port tx, output, 1, serial line, 8N1, LSB first, idle high, driven from a flop.
REQ-009 Port busy, output, 1, frame in progress (state != IDLE).
REQ-010 Port tx_done, output, 1, single-cycle pulse at the end of each stop bit.
REQ-011 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, bytes currently queued (excluding the byte being shifted).

Function
REQ-012 A byte SHALL be written to the FIFO on a clk edge where in_valid && in_ready; in_ready = (fifo_count < FIFO_DEPTH).
REQ-013 in_valid while in_ready=0 SHALL be ignored; the byte is dropped and the FIFO contents and count are unchanged.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, encoded in a 2-bit enum.
REQ-015 In IDLE with fifo_count > 0, the next edge SHALL pop the head byte into an 8-bit shift register, set tx=0, clear the baud counter and bit index, and enter START.
REQ-016 Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE SHALL drive tx low from edge k+1.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1; each bit period lasts exactly CLKS_PER_BIT clk cycles.
REQ-018 START SHALL last one bit period, then go to DATA with tx = shift[0].
REQ-019 DATA SHALL emit 8 bits LSB first, shifting right once per bit period; after bit 7 it SHALL go to STOP with tx=1.
REQ-020 STOP SHALL last one bit period, and tx_done SHALL pulse on its final cycle.
REQ-021 At the end of STOP with fifo_count > 0, the FSM SHALL pop the next byte and enter START directly, with zero idle cycles between frames.
REQ-022 At the end of STOP with the FIFO empty, the FSM SHALL return to IDLE with tx=1.
REQ-023 A full frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
REQ-024 On a simultaneous write and pop in the same edge, the FIFO SHALL perform both and leave fifo_count unchanged; this applies when full as well, with in_ready evaluated before the edge.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with no loss or reorder of bytes.
REQ-026 in_data SHALL NOT affect a frame already loaded into the shift register.

Reset
REQ-027 On rst=1 at an edge: tx=1, busy=0, tx_done=0, state=IDLE, FIFO flushed (count 0, pointers 0), and in_ready=1 on the following cycle.
REQ-028 Reset mid-frame SHALL abort the frame immediately, driving tx high from the next edge, with no partial-frame completion and no tx_done.
REQ-029 rst SHALL take priority over every other event, including a write in the same cycle.

Structure
REQ-030 Package uart_pkg SHALL hold the tx state enum type, the UART_DATA_BITS=8 constant, and the default CLKS_PER_BIT constant shared with the receiver.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count), instantiated once.
REQ-032 The FSM, baud counter and shift register SHALL reside in uart_tx_buffered.

Verification
REQ-033 All benches SHALL run with CLKS_PER_BIT=16.
REQ-034 Single byte 0x41 into an idle block -> tx low from edge k+1; line shows 0,1,0,0,0,0,0,1,0,1 with 16 cycles per bit; tx_done pulses once at cycle 160; busy falls afterwards.
REQ-035 Burst 0x55, 0xAA, 0x00 written on consecutive cycles -> three frames back-to-back with no idle gap; 480 cycles total; 3 tx_done pulses.
REQ-036 Write 9 bytes with FIFO_DEPTH=8 while the first frame is active -> the first byte goes to the shift register and bytes 2..9 fill the FIFO; a 10th write with in_ready=0 is dropped; 9 frames are transmitted in order.
REQ-037 Assert rst at cycle 70 of a frame carrying 0xF0 -> tx=1 from the next edge, fifo_count=0, no tx_done pulse, and the line stays idle.
REQ-038 Loopback into the existing receiver at matching baud, sending 256 random bytes -> every received byte equals the byte sent and the receiver's done-pulse count is 256.
